aq_djpeg_bitbuf: RTL and testbench
==================================

AQ_DJPEG_BITBUF -- requirements
Module: aq_djpeg_bitbuf

Interface
REQ-001 SHALL have parameter IN_BYTES, default 4, meaning the input word width in bytes; legal values are 4 and 8.
REQ-002 SHALL have parameter BUF_BITS, default 128, meaning the bit-buffer capacity; it is a multiple of 32 and at least 64+8*IN_BYTES.
REQ-003 SHALL have parameter PEEK_W, default 32, meaning the peek window width in bits; legal values are 16 and 32.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port din, input, 8*IN_BYTES bits: stream bytes; the first byte is in [7:0].
REQ-007 SHALL have port din_valid, input, 1 bit, and port din_ready, output, 1 bit: the input handshake.
REQ-008 SHALL have port image_en, input, 1 bit: scan mode (unstuffing and marker detection on); when low, header mode.
REQ-009 SHALL have port proc_idle, input, 1 bit: downstream idle; clears the end state.
REQ-010 SHALL have port peek, output, PEEK_W bits: the next unconsumed bits, MSB-aligned, zero-filled.
REQ-011 SHALL have port avail, output, $clog2(BUF_BITS+1) bits: the number of valid buffered bits.
REQ-012 SHALL have port peek_valid, output, 1 bit: high when avail >= PEEK_W or data_end=1.
REQ-013 SHALL have port use_en, input, 1 bit, and port use_width, input, $clog2(PEEK_W+1) bits: consume use_width bits.
REQ-014 SHALL have port align, input, 1 bit: discard bits down to the next byte boundary.
REQ-015 SHALL have port data_end, output, 1 bit: EOI (FFD9) seen in scan mode.
REQ-016 SHALL have port rst_mark, output, 1 bit, and port rst_idx, output, 3 bits: RSTn marker pulse and its index n.
REQ-017 SHALL have port err, output, 1 bit: sticky underflow error (consume exceeding avail).

Function
REQ-018 SHALL run FSM states HDR, SCAN and END: HDR->SCAN on image_en=1; SCAN->END on detecting FFD9; END->HDR when proc_idle=1 and avail=0; any state->HDR when image_en=0 and not in END.
REQ-019 SHALL assert din_ready = (BUF_BITS-avail >= 8*IN_BYTES) & state!=END, and accept a word on din_valid & din_ready.
REQ-020 SHALL, in HDR, append all bytes unmodified.
REQ-021 SHALL, in SCAN, replace each FF00 with FF, process byte lanes in order, and carry a word-final FF to the next word (carry flag).
REQ-022 SHALL, in SCAN, remove FFD0..FFD7 from the stream without appending them, pulse rst_mark for one cycle with rst_idx=n, and place it in order after the preceding data bytes have been appended.
REQ-023 SHALL, in SCAN, not append FFD9 or any later byte of that word, and SHALL enter END.
REQ-024 SHALL apply accepted bytes to the buffer 1 cycle after the handshake (unstuff pipeline register), so avail rises at cycle N+2.
REQ-025 SHALL register peek/avail/peek_valid; a consume at cycle N is reflected at N+1.
REQ-026 SHALL apply a simultaneous append and consume in the same cycle: avail_next = avail + appended - consumed.
REQ-027 SHALL give use_en priority over align when both are asserted; align yields avail_next = avail rounded down to a multiple of 8.
REQ-028 SHALL, when use_width > avail, set err, set avail to 0, and hold err until reset.
REQ-029 SHALL never drop input bytes: din_ready only guarantees space for the worst case of 8*IN_BYTES appended bits.

Reset
REQ-030 SHALL, on rst=0 asynchronously, drive state=HDR, avail=0, peek=0, peek_valid=0, din_ready=0, data_end=0, rst_mark=0, rst_idx=0, err=0, carry cleared, pipeline emptied.
REQ-031 SHALL discard partially processed words when reset is asserted mid-transfer, with no pulse emitted after release.

Configuration
REQ-032 SHALL compile RSTn handling (REQ-022) when AQ_DJPEG_RSTMARK_EN is defined.
REQ-033 SHALL, when AQ_DJPEG_RSTMARK_EN is undefined, tie rst_mark and rst_idx to 0 and silently discard FFD0..FFD7 byte pairs.

Structure
REQ-034 SHALL place marker constants (FF, 00, D0..D7, D9) and the state enum in package aq_djpeg_pkg.
REQ-035 SHALL implement per-word stuffing removal and marker detection in sub-module aq_djpeg_unstuff, which outputs compacted bytes, a byte count, the carry flag, and marker info.

Verification
REQ-036 SHALL verify: HDR mode, din=32'h44332211 -> peek=32'h11223344, avail=32 at cycle +2.
REQ-037 SHALL verify: SCAN mode, bytes 12 FF 00 34 -> avail=24, peek[31:8]=24'h12FF34.
REQ-038 SHALL verify: SCAN mode, FF as the last byte of word 1 and 00 as the first byte of word 2 -> exactly one FF appended, carry cleared.
REQ-039 SHALL verify: AQ_DJPEG_RSTMARK_EN defined, bytes AB FF D3 CD -> rst_mark pulse with rst_idx=3, appended 16'hABCD; then align with avail=13 -> avail=8.
REQ-040 SHALL verify: bytes 55 FF D9 xx -> data_end=1, din_ready=0; then proc_idle=1 with avail=0 -> state HDR, data_end=0.
REQ-041 SHALL verify: use_width=20 with avail=12 -> err=1, avail=0; then rst low mid-word -> all outputs at reset values.

Source files
------------

// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG entropy-stream bit buffer.
// Contents: JPEG marker byte constants, the bit-buffer FSM state type, and a
// helper that classifies restart-marker codes (FFD0..FFD7).
package aq_djpeg_pkg;

  localparam logic [7:0] MK_FF    = 8'hFF;
  localparam logic [7:0] MK_STUFF = 8'h00;
  localparam logic [7:0] MK_RST0  = 8'hD0;
  localparam logic [7:0] MK_RST1  = 8'hD1;
  localparam logic [7:0] MK_RST2  = 8'hD2;
  localparam logic [7:0] MK_RST3  = 8'hD3;
  localparam logic [7:0] MK_RST4  = 8'hD4;
  localparam logic [7:0] MK_RST5  = 8'hD5;
  localparam logic [7:0] MK_RST6  = 8'hD6;
  localparam logic [7:0] MK_RST7  = 8'hD7;
  localparam logic [7:0] MK_EOI   = 8'hD9;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_SCAN = 2'd1,
    ST_END  = 2'd2
  } bitbufState_t;

  function automatic logic isRstMarker(input logic [7:0] code);
    return (code >= MK_RST0) && (code <= MK_RST7);
  endfunction

endpackage

// File: rtl/aq_djpeg_unstuff.sv
// Per-word byte-stuffing removal and marker detection (combinational).
// Ports:
//   din       - input word, first stream byte in [7:0]
//   carryIn   - an FF ended the previous word and is still pending
//   scanMode  - 1: unstuff and detect markers; 0: pass every byte through
//   outBytes  - compacted output bytes, first byte in [7:0], unused lanes zero
//   outCnt    - number of valid bytes in outBytes
//   carryOut  - this word ends with a pending FF
//   rstHit    - an RSTn marker was removed from this word
//   rstIdx    - n of the last RSTn marker in this word
//   eoi       - FFD9 found; it and all later bytes of the word are dropped
// In scan mode an FF followed by FF is treated as fill (the first FF is
// dropped, the second stays pending); FF followed by any other non-stuff,
// non-RSTn, non-EOI code is dropped as an unsupported marker pair. This keeps
// the output count bounded by IN_BYTES.
module aq_djpeg_unstuff
  import aq_djpeg_pkg::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic [8*IN_BYTES-1:0]        din,
  input  logic                         carryIn,
  input  logic                         scanMode,
  output logic [8*IN_BYTES-1:0]        outBytes,
  output logic [$clog2(IN_BYTES+1)-1:0] outCnt,
  output logic                         carryOut,
  output logic                         rstHit,
  output logic [2:0]                   rstIdx,
  output logic                         eoi
);

  localparam int CW = $clog2(IN_BYTES+1);

  logic [7:0]    b;
  logic          pend;
  logic          stop;
  logic [CW-1:0] cnt;

  always_comb begin
    outBytes = '0;
    cnt      = '0;
    pend     = carryIn & scanMode;
    stop     = 1'b0;
    rstHit   = 1'b0;
    rstIdx   = '0;
    eoi      = 1'b0;
    b        = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      b = din[8*i +: 8];
      if (!stop) begin
        if (!scanMode) begin
          outBytes[8*cnt +: 8] = b;
          cnt = cnt + CW'(1);
        end else if (pend) begin
          if (b == MK_STUFF) begin
            outBytes[8*cnt +: 8] = MK_FF;
            cnt  = cnt + CW'(1);
            pend = 1'b0;
          end else if (b == MK_FF) begin
            pend = 1'b1;
          end else if (isRstMarker(b)) begin
            rstHit = 1'b1;
            rstIdx = b[2:0];
            pend   = 1'b0;
          end else if (b == MK_EOI) begin
            eoi  = 1'b1;
            stop = 1'b1;
            pend = 1'b0;
          end else begin
            pend = 1'b0;
          end
        end else if (b == MK_FF) begin
          pend = 1'b1;
        end else begin
          outBytes[8*cnt +: 8] = b;
          cnt = cnt + CW'(1);
        end
      end
    end
    outCnt   = cnt;
    carryOut = pend;
  end

endmodule

// File: rtl/aq_djpeg_bitbuf.sv
// JPEG bit buffer: accepts stream words, removes byte stuffing and markers in
// scan mode, and presents an MSB-aligned peek window to the Huffman decoder.
// Optional feature: define AQ_DJPEG_RSTMARK_EN to report RSTn markers on
// rst_mark/rst_idx; otherwise those markers are dropped silently.
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   din/din_valid/din_ready - input word handshake, first byte in din[7:0]
//   image_en            - 1: scan mode, 0: header mode
//   proc_idle           - downstream idle; allows leaving the end state
//   peek/avail/peek_valid - next unconsumed bits, valid bit count, window valid
//   use_en/use_width    - consume use_width bits
//   align               - drop bits down to the next byte boundary
//   data_end            - EOI seen in scan mode
//   rst_mark/rst_idx    - RSTn pulse and index
//   err                 - sticky consume-underflow flag
module aq_djpeg_bitbuf
  import aq_djpeg_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int BUF_BITS = 128,
  parameter int PEEK_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*IN_BYTES-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          image_en,
  input  logic                          proc_idle,
  output logic [PEEK_W-1:0]             peek,
  output logic [$clog2(BUF_BITS+1)-1:0] avail,
  output logic                          peek_valid,
  input  logic                          use_en,
  input  logic [$clog2(PEEK_W+1)-1:0]   use_width,
  input  logic                          align,
  output logic                          data_end,
  output logic                          rst_mark,
  output logic [2:0]                    rst_idx,
  output logic                          err
);

  localparam int IW        = 8*IN_BYTES;
  localparam int AW        = $clog2(BUF_BITS+1);
  localparam int CW        = $clog2(IN_BYTES+1);
  localparam int SPACE_LIM = BUF_BITS - IW;

  bitbufState_t        state, stateN;
  logic                carry, carryN;
  logic [BUF_BITS-1:0] bitBuf, bitBufN;

  logic                accept;
  logic [IW-1:0]       outBytes;
  logic [CW-1:0]       outCnt;
  logic                carryOut, mkHit, eoi;
  logic [2:0]          mkIdx;

  logic                vld_p1;
  logic [IW-1:0]       bytes_p1;
  logic [CW-1:0]       cnt_p1;

  logic [IW-1:0]       newWord;
  logic [AW-1:0]       appBits, pendBits, consumeN, availMid, availN;
  logic                underflow, readyN;

  assign accept   = din_valid & din_ready;
  assign data_end = (state == ST_END);
  assign peek     = bitBuf[BUF_BITS-1 -: PEEK_W];

  aq_djpeg_unstuff #(.IN_BYTES(IN_BYTES)) uUnstuff (
    .din      (din),
    .carryIn  (carry),
    .scanMode (state == ST_SCAN),
    .outBytes (outBytes),
    .outCnt   (outCnt),
    .carryOut (carryOut),
    .rstHit   (mkHit),
    .rstIdx   (mkIdx),
    .eoi      (eoi)
  );

  always_comb begin
    // Stage p1 -> buffer: reorder lanes so the first byte lands at the MSB.
    newWord = '0;
    if (vld_p1) begin
      for (int i = 0; i < IN_BYTES; i++) begin
        newWord[IW-8-8*i +: 8] = bytes_p1[8*i +: 8];
      end
    end
    appBits  = vld_p1 ? (AW'(cnt_p1) << 3) : '0;
    pendBits = accept ? (AW'(outCnt) << 3) : '0;

    // Underflow consumes everything that is buffered, which empties the
    // buffer because bits below avail are always zero.
    underflow = use_en && (AW'(use_width) > avail);
    if (use_en)     consumeN = underflow ? avail : AW'(use_width);
    else if (align) consumeN = {{(AW-3){1'b0}}, avail[2:0]};
    else            consumeN = '0;

    availMid = avail - consumeN;
    availN   = availMid + appBits;
    bitBufN  = (bitBuf << consumeN) | ({newWord, {(BUF_BITS-IW){1'b0}}} >> availMid);

    stateN = state;
    case (state)
      ST_HDR:  if (image_en) stateN = ST_SCAN;
      ST_SCAN: begin
        if (accept && eoi)  stateN = ST_END;
        else if (!image_en) stateN = ST_HDR;
      end
      ST_END:  if (proc_idle && (avail == '0) && !vld_p1) stateN = ST_HDR;
      default: stateN = ST_HDR;
    endcase

    if (state != ST_SCAN) carryN = 1'b0;
    else if (accept)      carryN = carryOut;
    else                  carryN = carry;

    // Space check includes a word still sitting in the unstuff register so
    // a back-to-back accept can never overflow the buffer.
    readyN = (stateN != ST_END) &&
             (({1'b0, availN} + {1'b0, pendBits}) <= (AW+1)'(SPACE_LIM));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_HDR;
      carry      <= 1'b0;
      vld_p1     <= 1'b0;
      bitBuf     <= '0;
      avail      <= '0;
      peek_valid <= 1'b0;
      din_ready  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= stateN;
      carry      <= carryN;
      vld_p1     <= accept;
      bitBuf     <= bitBufN;
      avail      <= availN;
      peek_valid <= (availN >= AW'(PEEK_W)) || (stateN == ST_END);
      din_ready  <= readyN;
      if (underflow) err <= 1'b1;
    end
  end

  // Stage p0 -> p1: unstuffed word captured at the handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      bytes_p1 <= outBytes;
      cnt_p1   <= outCnt;
    end
  end

`ifdef AQ_DJPEG_RSTMARK_EN
  logic       mk_p1;
  logic [2:0] mkIdx_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      mk_p1    <= mkHit;
      mkIdx_p1 <= mkIdx;
    end
  end

  // Pulse coincides with the append, so the bytes preceding the marker are
  // already in avail when rst_mark is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_mark <= 1'b0;
      rst_idx  <= '0;
    end else begin
      rst_mark <= vld_p1 & mk_p1;
      if (vld_p1 & mk_p1) rst_idx <= mkIdx_p1;
    end
  end
`else
  logic unusedMk;
  assign unusedMk = ^{mkHit, mkIdx};
  assign rst_mark = 1'b0;
  assign rst_idx  = '0;
`endif

endmodule

// File: tb/tb_aq_djpeg_bitbuf.sv
module tb_aq_djpeg_bitbuf;

  localparam int IN_BYTES = 4;
  localparam int BUF_BITS = 128;
  localparam int PEEK_W   = 32;
  localparam int AW       = $clog2(BUF_BITS+1);
  localparam int UW       = $clog2(PEEK_W+1);
`ifdef AQ_DJPEG_RSTMARK_EN
  localparam bit MK_EN = 1'b1;
`else
  localparam bit MK_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [8*IN_BYTES-1:0] din = '0;
  logic                  din_valid = 1'b0;
  logic                  din_ready;
  logic                  image_en = 1'b0;
  logic                  proc_idle = 1'b0;
  logic [PEEK_W-1:0]     peek;
  logic [AW-1:0]         avail;
  logic                  peek_valid;
  logic                  use_en = 1'b0;
  logic [UW-1:0]         use_width = '0;
  logic                  align = 1'b0;
  logic                  data_end;
  logic                  rst_mark;
  logic [2:0]            rst_idx;
  logic                  err;

  always #5 clk = ~clk;

  aq_djpeg_bitbuf #(.IN_BYTES(IN_BYTES), .BUF_BITS(BUF_BITS), .PEEK_W(PEEK_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .image_en(image_en), .proc_idle(proc_idle), .peek(peek), .avail(avail),
    .peek_valid(peek_valid), .use_en(use_en), .use_width(use_width), .align(align),
    .data_end(data_end), .rst_mark(rst_mark), .rst_idx(rst_idx), .err(err)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the buffered stream as a queue of bits, front = next bit.
  bit         mq[$];
  bit         mScan, mPend, mEnd, mErr, mRstHit, mEoi;
  logic [2:0] mRstIdx, mLastIdx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelPush(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) mq.push_back(b[k]);
  endfunction

  function automatic void modelClear();
    mq.delete();
    mScan = 0; mPend = 0; mEnd = 0; mErr = 0; mRstHit = 0; mEoi = 0;
    mRstIdx = '0; mLastIdx = '0;
  endfunction

  function automatic void modelWord(input logic [31:0] w);
    bit         done;
    logic [7:0] b;
    done = 0; mRstHit = 0; mEoi = 0;
    for (int i = 0; i < IN_BYTES; i++) begin
      b = w[8*i +: 8];
      if (!done) begin
        if (!mScan) modelPush(b);
        else if (mPend) begin
          mPend = 0;
          if (b == 8'h00) modelPush(8'hFF);
          else if (b == 8'hFF) mPend = 1;
          else if (b == 8'hD9) begin mEoi = 1; done = 1; end
          else if (b >= 8'hD0 && b <= 8'hD7) begin mRstHit = 1; mRstIdx = b[2:0]; end
        end
        else if (b == 8'hFF) mPend = 1;
        else modelPush(b);
      end
    end
    if (mEoi) begin mEnd = 1; mScan = 0; mPend = 0; end
    if (MK_EN && mRstHit) mLastIdx = mRstIdx;
  endfunction

  function automatic logic [PEEK_W-1:0] expPeek();
    logic [PEEK_W-1:0] r;
    r = '0;
    for (int i = 0; i < PEEK_W && i < mq.size(); i++) r[PEEK_W-1-i] = mq[i];
    return r;
  endfunction

  function automatic bit expReady();
    return !mEnd && ((BUF_BITS - mq.size()) >= 8*IN_BYTES);
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".avail"}, 64'(avail), 64'(mq.size()));
    chk({tag, ".peek"}, 64'(peek), 64'(expPeek()));
    chk({tag, ".pvld"}, 64'(peek_valid), 64'((mq.size() >= PEEK_W) || mEnd));
    chk({tag, ".rdy"}, 64'(din_ready), 64'(expReady()));
    chk({tag, ".end"}, 64'(data_end), 64'(mEnd));
    chk({tag, ".err"}, 64'(err), 64'(mErr));
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".avail"}, 64'(avail), 64'd0);
    chk({tag, ".peek"}, 64'(peek), 64'd0);
    chk({tag, ".pvld"}, 64'(peek_valid), 64'd0);
    chk({tag, ".rdy"}, 64'(din_ready), 64'd0);
    chk({tag, ".end"}, 64'(data_end), 64'd0);
    chk({tag, ".mark"}, 64'(rst_mark), 64'd0);
    chk({tag, ".idx"}, 64'(rst_idx), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd0);
  endtask

  // Handshake edge, then the append edge; returns sampled after the append.
  task automatic sendWord(input logic [31:0] w);
    int n;
    n = 0;
    din = w; din_valid = 1'b1;
    while (!din_ready && n < 50) begin tick(); n++; end
    if (!din_ready) begin
      chk("send.ready", 64'(din_ready), 64'd1);
      din_valid = 1'b0;
    end else begin
      tick();
      din_valid = 1'b0;
      modelWord(w);
    end
    tick();
  endtask

  task automatic doUse(input int w);
    use_en = 1'b1; use_width = UW'(w);
    tick();
    use_en = 1'b0;
    if (w > mq.size()) begin mErr = 1; mq.delete(); end
    else repeat (w) void'(mq.pop_front());
  endtask

  task automatic doAlign();
    int d;
    align = 1'b1;
    tick();
    align = 1'b0;
    d = mq.size() % 8;
    repeat (d) void'(mq.pop_front());
  endtask

  task automatic setMode(input bit scan);
    image_en = scan;
    tick();
    mScan = scan;
    if (!scan) mPend = 0;
  endtask

  function automatic logic [7:0] scanByte();
    int         s;
    logic [7:0] b;
    s = $urandom_range(0, 9);
    b = 8'($urandom_range(0, 255));
    if (s < 2) b = 8'hFF;
    else if (s < 4) b = 8'h00;
    else if (s == 4) b = 8'hD0 | 8'($urandom_range(0, 7));
    if (b == 8'hD9) b = 8'hD8;
    return b;
  endfunction

  task automatic randomPhase(input string tag, input int iters);
    logic [31:0] w;
    int          op, lim;
    for (int it = 0; it < iters; it++) begin
      op = $urandom_range(0, 4);
      if (op <= 1 && expReady()) begin
        if (mScan) w = {scanByte(), scanByte(), scanByte(), scanByte()};
        else w = $urandom;
        sendWord(w);
        chk({tag, ".mark"}, 64'(rst_mark), 64'(MK_EN && mRstHit));
        chk({tag, ".idx"}, 64'(rst_idx), 64'(mLastIdx));
      end else if (op <= 3 && mq.size() > 0) begin
        lim = (mq.size() < PEEK_W) ? mq.size() : PEEK_W;
        doUse($urandom_range(1, lim));
      end else begin
        doAlign();
      end
      checkAll(tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", nPass, nChecks);
    $fatal(1);
  end

  initial begin
    modelClear();
    tick(); tick();
    checkReset("rst");
    rst = 1'b1;
    tick();
    chk("rst.rdyUp", 64'(din_ready), 64'd1);

    // Header mode pass-through, two-cycle latency.
    din = 32'h44332211; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("hdr.lat", 64'(avail), 64'd0);
    modelWord(32'h44332211);
    tick();
    chk("hdr.avail", 64'(avail), 64'd32);
    chk("hdr.peek", 64'(peek), 64'h11223344);
    checkAll("hdr");
    doUse(32);
    checkAll("hdr.drain");

    // Scan mode stuffing removal.
    setMode(1);
    sendWord(32'h3400FF12);
    chk("stuff.avail", 64'(avail), 64'd24);
    chk("stuff.peek", 64'(peek[31:8]), 64'h12FF34);
    doUse(24);

    // FF at the end of one word, 00 at the start of the next.
    sendWord(32'hFF332211);
    chk("carry.peek1", 64'(peek), 64'h11223300);
    sendWord(32'h66554400);
    chk("carry.avail", 64'(avail), 64'd56);
    doUse(24);
    chk("carry.peek2", 64'(peek), 64'hFF445566);
    doUse(32);
    sendWord(32'h99887700);
    chk("carry.clr", 64'(peek), 64'h00778899);
    checkAll("carry");
    doUse(32);

    // Restart marker removal, alignment and use/align priority.
    sendWord(32'hCDD3FFAB);
    chk("rstm.mark", 64'(rst_mark), 64'(MK_EN));
    chk("rstm.idx", 64'(rst_idx), 64'(MK_EN ? 3 : 0));
    chk("rstm.avail", 64'(avail), 64'd16);
    chk("rstm.peek", 64'(peek), 64'hABCD0000);
    tick();
    chk("rstm.pulse", 64'(rst_mark), 64'd0);
    doUse(3);
    chk("align.pre", 64'(avail), 64'd13);
    doAlign();
    chk("align.avail", 64'(avail), 64'd8);
    chk("align.peek", 64'(peek), 64'hCD000000);
    use_en = 1'b1; use_width = UW'(2); align = 1'b1;
    tick();
    use_en = 1'b0; align = 1'b0;
    repeat (2) void'(mq.pop_front());
    chk("prio.avail", 64'(avail), 64'd6);
    doAlign();
    checkAll("prio");

    // Append and consume in the same cycle.
    sendWord(32'h04030201);
    doUse(24);
    din = 32'h08070605; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    use_en = 1'b1; use_width = UW'(5);
    tick();
    use_en = 1'b0;
    modelWord(32'h08070605);
    repeat (5) void'(mq.pop_front());
    chk("simul.avail", 64'(avail), 64'd35);
    checkAll("simul");
    doUse(32); doUse(3);

    // End of image and return to header mode.
    sendWord(32'hEED9FF55);
    chk("eoi.end", 64'(data_end), 64'd1);
    chk("eoi.rdy", 64'(din_ready), 64'd0);
    chk("eoi.peek", 64'(peek), 64'h55000000);
    checkAll("eoi");
    proc_idle = 1'b1;
    image_en = 1'b0;
    tick();
    chk("eoi.hold", 64'(data_end), 64'd1);
    doUse(8);
    tick();
    mEnd = 0; mScan = 0; mPend = 0;
    chk("eoi.exit", 64'(data_end), 64'd0);
    checkAll("eoi.hdr");
    proc_idle = 1'b0;

    // Underflow error, then reset in the middle of a transfer.
    sendWord(32'h00002211);
    doUse(20);
    chk("uf.pre", 64'(avail), 64'd12);
    doUse(20);
    chk("uf.err", 64'(err), 64'd1);
    chk("uf.avail", 64'(avail), 64'd0);
    tick();
    chk("uf.sticky", 64'(err), 64'd1);
    din = 32'hA5A5A5A5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    #1 rst = 1'b0;
    #1 checkReset("midrst");
    modelClear();
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("midrst.mark", 64'(rst_mark), 64'd0);
    checkAll("midrst.post");

    randomPhase("rndHdr", 120);
    setMode(1);
    randomPhase("rndScan", 200);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
